// File: rtl/usb_ahb_pkg.sv
// usb_ahb_pkg: shared types and constants for the AHB-Lite USB slave.
// Revision 1.0
`default_nettype none
package usb_ahb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REG_XFER = 3'd1,
        ST_RD_DATA  = 3'd2,
        ST_WR_CAP   = 3'd3,
        ST_WR_DATA  = 3'd4,
        ST_ERR1     = 3'd5,
        ST_ERR2     = 3'd6
    } state_t;

    localparam logic [1:0] c_HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] c_HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] c_HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] c_HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] c_HSIZE_BYTE = 3'd0;
    localparam logic [2:0] c_HSIZE_HALF = 3'd1;
    localparam logic [2:0] c_HSIZE_WORD = 3'd2;

    localparam logic [3:0] c_ADDR_STATUS = 4'h4;
    localparam logic [3:0] c_ADDR_ERROR  = 4'h6;
    localparam logic [3:0] c_ADDR_OCC    = 4'h8;
    localparam logic [3:0] c_ADDR_TXPKT  = 4'hC;
    localparam logic [3:0] c_ADDR_FLUSH  = 4'hD;
    localparam logic [3:0] c_ADDR_IRQEN  = 4'hE;

    // 32-bit word index, haddr[3:2]
    localparam logic [1:0] c_WORD_DATA = 2'd0;
    localparam logic [1:0] c_WORD_STAT = 2'd1;
    localparam logic [1:0] c_WORD_OCC  = 2'd2;
    localparam logic [1:0] c_WORD_CTRL = 2'd3;

    localparam logic [2:0] c_RX_NONE  = 3'd0;
    localparam logic [2:0] c_RX_OUT   = 3'd1;
    localparam logic [2:0] c_RX_IN    = 3'd2;
    localparam logic [2:0] c_RX_DATA0 = 3'd3;
    localparam logic [2:0] c_RX_DATA1 = 3'd4;
    localparam logic [2:0] c_RX_ACK   = 3'd5;
    localparam logic [2:0] c_RX_NAK   = 3'd6;

    function automatic logic [3:0] lane_mask(input logic [1:0] off, input logic [2:0] size);
        case (size)
            c_HSIZE_BYTE: lane_mask = 4'b0001 << off;
            c_HSIZE_HALF: lane_mask = 4'b0011 << off;
            default:      lane_mask = 4'b1111;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/usb_ahb_byte_sequencer.sv
// usb_ahb_byte_sequencer: byte counter and lane steering for data-window bursts.
// Revision 1.0
`default_nettype none
module usb_ahb_byte_sequencer (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        i_load,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_last,
    input  logic        i_rd_step,
    input  logic        i_wr_cap,
    input  logic        i_wr_step,
    input  logic [7:0]  i_rx_data,
    input  logic [31:0] i_hwdata,
    output logic        o_get_rx_data,
    output logic        o_store_tx_data,
    output logic [7:0]  o_tx_data,
    output logic [31:0] o_rdata,
    output logic        o_done
);

    logic [1:0]  r_off;
    logic [1:0]  r_last;
    logic [1:0]  r_k;
    logic [31:0] r_rbuf;
    logic [31:0] r_wbuf;
    logic [1:0]  w_lane;

    // Aligned transfers never carry past lane 3, so the 2-bit sum is exact.
    assign w_lane = r_off + r_k;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_off  <= 2'd0;
            r_last <= 2'd0;
            r_k    <= 2'd0;
            r_rbuf <= 32'd0;
            r_wbuf <= 32'd0;
        end else begin
            if (i_load) begin
                r_off  <= i_offset;
                r_last <= i_last;
                r_k    <= 2'd0;
                r_rbuf <= 32'd0;
            end else begin
                if (i_rd_step || i_wr_step)
                    r_k <= r_k + 2'd1;
                if (i_rd_step)
                    r_rbuf[{w_lane, 3'b000} +: 8] <= i_rx_data;
            end
            if (i_wr_cap)
                r_wbuf <= i_hwdata;
        end
    end

    assign o_get_rx_data   = i_rd_step;
    assign o_store_tx_data = i_wr_step;
    assign o_tx_data       = i_wr_step ? r_wbuf[{w_lane, 3'b000} +: 8] : 8'h00;
    assign o_rdata         = r_rbuf;
    assign o_done          = (r_k == r_last);

endmodule
`default_nettype wire

// File: rtl/ahb_lite_usb_slave_v2.sv
// ahb_lite_usb_slave_v2: AHB-Lite slave for the USB RX/TX engines and data buffer.
// Optional irq output and 0xE irq_enable register under USB_AHB_IRQ_EN. Revision 1.0
`default_nettype none
module ahb_lite_usb_slave_v2
    import usb_ahb_pkg::*;
#(
    parameter  int BUF_DEPTH = 64,
    parameter  int RX_PKT_W  = 3,
    parameter  int TX_PKT_W  = 2,
    localparam int OCC_W     = $clog2(BUF_DEPTH) + 1
) (
`ifdef USB_AHB_IRQ_EN
    output logic                irq,
`endif
    input  logic                clk,
    input  logic                n_rst,
    input  logic                hsel,
    input  logic [3:0]          haddr,
    input  logic [1:0]          htrans,
    input  logic [2:0]          hsize,
    input  logic                hwrite,
    input  logic [31:0]         hwdata,
    output logic [31:0]         hrdata,
    output logic                hready,
    output logic                hresp,
    input  logic [RX_PKT_W-1:0] rx_packet,
    input  logic                rx_data_ready,
    input  logic                rx_transfer_active,
    input  logic                rx_error,
    input  logic                tx_transfer_active,
    input  logic                tx_error,
    input  logic [OCC_W-1:0]    buffer_occupancy,
    input  logic [7:0]          rx_data,
    output logic                get_rx_data,
    output logic                store_tx_data,
    output logic [7:0]          tx_data,
    output logic [TX_PKT_W-1:0] tx_packet,
    output logic                d_mode,
    output logic                clear
);

    localparam logic [OCC_W:0] c_DEPTH = (OCC_W + 1)'(BUF_DEPTH);

    state_t              r_state;
    state_t              w_next;
    state_t              w_dec;
    logic [3:0]          r_addr;
    logic                r_write;
    logic [3:0]          r_mask;
    logic                r_rx_err;
    logic                r_tx_err;
    logic                r_d_mode;
    logic                r_clear;
    logic [TX_PKT_W-1:0] r_tx_packet;
    logic [7:0]          w_irq_en_byte;

    logic w_ready, w_accept, w_is_data, w_err;
    logic w_bad_addr, w_bad_size, w_misalign, w_ro_write, w_underrun, w_overrun;
    logic [2:0]       w_n;
    logic [OCC_W:0]   w_n_ext;
    logic [OCC_W:0]   w_occ_ext;
    logic w_seq_load, w_rd_step, w_wr_cap, w_wr_step, w_seq_done;
    logic [31:0] w_seq_rdata;
    logic w_reg_phase, w_ctrl_wr, w_err_rd, w_tx_fall;
    logic [15:0] w_status;
    logic [15:0] w_err_word;

`ifdef USB_AHB_IRQ_EN
    localparam logic c_IRQ_PRESENT = 1'b1;
    logic [1:0] r_irq_en;
    logic       r_irq;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_irq_en <= 2'd0;
            r_irq    <= 1'b0;
        end else begin
            if (w_ctrl_wr && r_mask[2])
                r_irq_en <= hwdata[17:16];
            r_irq <= (r_irq_en[0] & rx_data_ready) | (r_irq_en[1] & (r_rx_err | r_tx_err));
        end
    end

    assign irq           = r_irq;
    assign w_irq_en_byte = 8'(r_irq_en);
`else
    localparam logic c_IRQ_PRESENT = 1'b0;
    assign w_irq_en_byte = 8'h00;
`endif

    // Address-phase decode; every error is settled before any side effect.
    assign w_accept   = hsel && (htrans == c_HTRANS_NONSEQ || htrans == c_HTRANS_SEQ) && w_ready;
    assign w_is_data  = (haddr[3:2] == c_WORD_DATA);
    assign w_n        = 3'd1 << hsize[1:0];
    assign w_n_ext    = (OCC_W + 1)'(w_n);
    assign w_occ_ext  = {1'b0, buffer_occupancy};
    assign w_bad_addr = (haddr == 4'hA) || (haddr == 4'hB) || (haddr == 4'hF) ||
                        ((haddr == c_ADDR_IRQEN) && !c_IRQ_PRESENT);
    assign w_bad_size = (hsize > c_HSIZE_WORD);
    assign w_misalign = ((hsize == c_HSIZE_HALF) && haddr[0]) ||
                        ((hsize == c_HSIZE_WORD) && (haddr[1:0] != 2'd0));
    assign w_ro_write = hwrite && (haddr >= c_ADDR_STATUS) && (haddr <= c_ADDR_OCC);
    assign w_underrun = w_is_data && !hwrite && (w_occ_ext < w_n_ext);
    assign w_overrun  = w_is_data && hwrite && ((w_occ_ext + w_n_ext) > c_DEPTH);
    assign w_err      = w_bad_addr || w_bad_size || w_misalign || w_ro_write || w_underrun || w_overrun;

    assign w_dec = w_err     ? ST_ERR1 :
                   w_is_data ? (hwrite ? ST_WR_CAP : ST_RD_DATA) : ST_REG_XFER;

    assign w_ready = !((r_state == ST_RD_DATA) || (r_state == ST_WR_CAP) || (r_state == ST_ERR1) ||
                       ((r_state == ST_WR_DATA) && !w_seq_done));
    assign hready  = w_ready;
    assign hresp   = (r_state == ST_ERR1) || (r_state == ST_ERR2);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_RD_DATA: if (w_seq_done) w_next = ST_REG_XFER;
            ST_WR_CAP:  w_next = ST_WR_DATA;
            ST_ERR1:    w_next = ST_ERR2;
            default:    ;
        endcase
        if (w_ready)
            w_next = w_accept ? w_dec : ST_IDLE;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= ST_IDLE;
            r_addr  <= 4'd0;
            r_write <= 1'b0;
            r_mask  <= 4'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr  <= haddr;
                r_write <= hwrite;
                r_mask  <= lane_mask(haddr[1:0], hsize);
            end
        end
    end

    assign w_seq_load = w_accept && !w_err && w_is_data;
    assign w_rd_step  = (r_state == ST_RD_DATA);
    assign w_wr_cap   = (r_state == ST_WR_CAP);
    assign w_wr_step  = (r_state == ST_WR_DATA);

    usb_ahb_byte_sequencer u_seq (
        .clk             (clk),
        .n_rst           (n_rst),
        .i_load          (w_seq_load),
        .i_offset        (haddr[1:0]),
        .i_last          ({hsize[1], hsize[1] | hsize[0]}),
        .i_rd_step       (w_rd_step),
        .i_wr_cap        (w_wr_cap),
        .i_wr_step       (w_wr_step),
        .i_rx_data       (rx_data),
        .i_hwdata        (hwdata),
        .o_get_rx_data   (get_rx_data),
        .o_store_tx_data (store_tx_data),
        .o_tx_data       (tx_data),
        .o_rdata         (w_seq_rdata),
        .o_done          (w_seq_done)
    );

    // Register data phase; read data sits on the byte lanes of its address.
    assign w_reg_phase = (r_state == ST_REG_XFER);
    assign w_ctrl_wr   = w_reg_phase && r_write && (r_addr[3:2] == c_WORD_CTRL);
    assign w_err_rd    = w_reg_phase && !r_write && (r_addr[3:2] == c_WORD_STAT) && (r_mask[2] || r_mask[3]);
    assign w_tx_fall   = r_d_mode && !tx_transfer_active;
    assign w_status    = 16'({rx_packet, tx_transfer_active, rx_transfer_active, rx_data_ready});
    assign w_err_word  = {7'd0, r_tx_err, 7'd0, r_rx_err};

    always_comb begin
        hrdata = 32'd0;
        if (w_reg_phase) begin
            case (r_addr[3:2])
                c_WORD_DATA: hrdata = w_seq_rdata;
                c_WORD_STAT: hrdata = {w_err_word, w_status};
                c_WORD_OCC:  hrdata = 32'(buffer_occupancy);
                default:     hrdata = {8'h00, w_irq_en_byte, 8'h00, 8'(r_tx_packet)};
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rx_err    <= 1'b0;
            r_tx_err    <= 1'b0;
            r_d_mode    <= 1'b0;
            r_clear     <= 1'b0;
            r_tx_packet <= '0;
        end else begin
            r_rx_err <= (r_rx_err && !w_err_rd) || rx_error;
            r_tx_err <= (r_tx_err && !w_err_rd) || tx_error;
            r_d_mode <= tx_transfer_active;
            r_clear  <= w_ctrl_wr && r_mask[1] && (hwdata[15:8] != 8'd0);
            if (w_ctrl_wr && r_mask[0])
                r_tx_packet <= hwdata[TX_PKT_W-1:0];
            else if (w_tx_fall)
                r_tx_packet <= '0;
        end
    end

    assign d_mode    = r_d_mode;
    assign clear     = r_clear;
    assign tx_packet = r_tx_packet;

endmodule
`default_nettype wire
